// File: rtl/dmem_responder.sv
// Data-memory responder for the dmem request/complete bus: captures one access
// per request, waits a programmable latency (stretched by stall), then completes.
module dmem_responder #(
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  input  logic        stall,
  output logic        complete_data,
  output logic [15:0] Data_dout,
  output logic        busy,
  output logic [15:0] access_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   cap_rd_q, cap_rd_d;
  logic [ADDR_BITS-1:0]   cap_addr_q, cap_addr_d;
  logic [15:0]            cap_din_q, cap_din_d;
  logic                   cd_q, cd_d;
  logic [15:0]            dout_q, dout_d;
  logic [15:0]            count_q, count_d;
  logic                   fire, mem_we;

  logic [15:0] mem [DEPTH];

  // Completion edge: counter expired and not held off by stall.
  assign fire   = (state_q == S_WAIT) && !stall && (cnt_q == 4'd0);
  assign mem_we = fire && !cap_rd_q && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cap_rd_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_din_q  <= 16'h0000;
      cd_q       <= 1'b0;
      dout_q     <= 16'h0000;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_rd_q   <= cap_rd_d;
      cap_addr_q <= cap_addr_d;
      cap_din_q  <= cap_din_d;
      cd_q       <= cd_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
    end
  end

  // Array is deliberately not reset; a write interrupted by reset never commits.
  always_ff @(posedge clock) begin
    if (mem_we) mem[cap_addr_q] <= cap_din_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Data_req) state_d = S_WAIT;
      S_WAIT:    if (fire) state_d = S_DONE;
      S_DONE:    state_d = Data_req ? S_RELEASE : S_IDLE;
      S_RELEASE: if (!Data_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    cap_rd_d   = cap_rd_q;
    cap_addr_d = cap_addr_q;
    cap_din_d  = cap_din_q;
    cd_d       = 1'b0;
    dout_d     = dout_q;
    count_d    = count_q;
    if (state_q == S_IDLE && Data_req) begin
      cap_rd_d   = Data_rd;
      cap_addr_d = Data_addr[ADDR_BITS-1:0];
      cap_din_d  = Data_din;
      cnt_d      = CNT_INIT;
    end
    if (state_q == S_WAIT && !stall && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    if (fire) begin
      cd_d    = 1'b1;
      count_d = count_q + 16'd1;
      if (cap_rd_q) dout_d = mem[cap_addr_q];
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign complete_data = cd_q;
  assign Data_dout     = dout_q;
  assign access_count  = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a transaction-level timeline model
// predicts every output each cycle; a few literal checks pin the model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset, Data_req, Data_rd, stall;
  logic [15:0] Data_addr, Data_din;
  logic        complete_data, busy;
  logic [15:0] Data_dout, access_count;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .Data_req(Data_req), .Data_rd(Data_rd),
    .Data_addr(Data_addr), .Data_din(Data_din), .stall(stall),
    .complete_data(complete_data), .Data_dout(Data_dout), .busy(busy),
    .access_count(access_count)
  );

  always #5 clock = ~clock;

  logic [15:0] mem_m [DEPTH];
  bit          written [DEPTH];
  logic        exp_cd, exp_busy;
  logic [15:0] exp_dout, exp_count;
  bit          chk_en;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      chk("complete_data", complete_data, exp_cd);
      chk("busy", busy, exp_busy);
      chk("Data_dout", Data_dout, exp_dout);
      chk("access_count", access_count, exp_count);
    end
  end

  // One full access: capture, latency (forced + random stall), optional held
  // request after completion, then release. lat = edges from capture to completion.
  task automatic access(input bit rd, input logic [15:0] addr, input logic [15:0] din,
                        input int hold, input int stall_n, input int stall_pct,
                        input bit perturb, output int lat);
    int rem, guard, idx, st_left;
    bit done;
    @(negedge clock);
    Data_req = 1'b1; Data_rd = rd; Data_addr = addr; Data_din = din;
    stall = 1'($urandom_range(0, 1));
    @(posedge clock);
    exp_busy = 1'b1; exp_cd = 1'b0;
    rem = LAT; lat = 0; done = 1'b0; guard = 0; st_left = stall_n;
    idx = int'(addr) % DEPTH;
    while (!done) begin
      @(negedge clock);
      if (perturb) begin
        Data_addr = 16'h0030; Data_din = 16'hFFFF;
      end else begin
        Data_addr = 16'($urandom); Data_din = 16'($urandom); Data_rd = 1'($urandom_range(0, 1));
      end
      if (st_left > 0) begin stall = 1'b1; st_left--; end
      else stall = ($urandom_range(0, 99) < stall_pct);
      @(posedge clock);
      lat++; guard++;
      if (!stall) rem--;
      if (rem == 0) begin
        done = 1'b1; exp_cd = 1'b1; exp_count++;
        if (rd) exp_dout = mem_m[idx];
        else begin mem_m[idx] = din; written[idx] = 1'b1; end
      end else if (guard > 100) begin
        chk("completion_timeout", 1, 0);
        done = 1'b1;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock); stall = 1'($urandom_range(0, 1));
      @(posedge clock); exp_cd = 1'b0;
    end
    @(negedge clock); Data_req = 1'b0; stall = 1'b0;
    @(posedge clock); exp_cd = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin
    int lat, c0, idx;
    bit rd;
    logic [15:0] a;
    reset = 1'b1; Data_req = 1'b0; Data_rd = 1'b0; stall = 1'b0;
    Data_addr = 16'h0; Data_din = 16'h0; chk_en = 1'b0;
    exp_cd = 1'b0; exp_busy = 1'b0; exp_dout = 16'h0; exp_count = 16'h0;
    #12;
    chk("rst_complete", complete_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", Data_dout, 16'h0000);
    chk("rst_count", access_count, 16'h0000);
    @(negedge clock); reset = 1'b0; chk_en = 1'b1;

    access(1'b0, 16'h0010, 16'h1234, 0, 0, 0, 1'b0, lat); #1;
    chk("t1_wr_latency", lat, 2);
    chk("t1_wr_count", access_count, 16'd1);
    access(1'b1, 16'h0010, 16'h0000, 0, 0, 0, 1'b0, lat); #1;
    chk("t1_rd_dout", Data_dout, 16'h1234);
    chk("t1_rd_count", access_count, 16'd2);

    access(1'b0, 16'h0105, 16'hBEEF, 0, 0, 0, 1'b0, lat);
    access(1'b1, 16'h0005, 16'h0000, 0, 0, 0, 1'b0, lat); #1;
    chk("wrap_dout", Data_dout, 16'hBEEF);

    access(1'b1, 16'h0010, 16'h0000, 0, 3, 0, 1'b0, lat); #1;
    chk("stall_latency", lat, LAT + 3);
    chk("stall_dout", Data_dout, 16'h1234);

    c0 = int'(access_count);
    access(1'b0, 16'h0040, 16'h4444, 5, 0, 0, 1'b0, lat); #1;
    chk("hold_count", access_count, 32'(c0 + 1));

    access(1'b0, 16'h0020, 16'hAAAA, 0, 0, 0, 1'b0, lat);
    @(negedge clock);
    Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0020; Data_din = 16'h5555;
    @(posedge clock); exp_busy = 1'b1; exp_cd = 1'b0;
    #2; reset = 1'b1; Data_req = 1'b0;
    exp_cd = 1'b0; exp_busy = 1'b0; exp_dout = 16'h0; exp_count = 16'h0;
    #1;
    chk("midrst_complete", complete_data, 0);
    chk("midrst_dout", Data_dout, 16'h0000);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", access_count, 16'h0000);
    @(negedge clock); @(negedge clock); reset = 1'b0;
    access(1'b1, 16'h0020, 16'h0000, 0, 0, 0, 1'b0, lat); #1;
    chk("midrst_mem_kept", Data_dout, 16'hAAAA);

    access(1'b0, 16'h0030, 16'h3030, 0, 0, 0, 1'b0, lat);
    access(1'b0, 16'h0031, 16'h0011, 0, 0, 0, 1'b1, lat);
    access(1'b1, 16'h0031, 16'h0000, 0, 0, 0, 1'b0, lat); #1;
    chk("capture_mem31", Data_dout, 16'h0011);
    access(1'b1, 16'h0030, 16'h0000, 0, 0, 0, 1'b0, lat); #1;
    chk("capture_mem30", Data_dout, 16'h3030);

    repeat (150) begin
      rd = 1'($urandom_range(0, 1));
      a = {8'($urandom), 4'h0, 4'($urandom)};
      idx = int'(a) % DEPTH;
      if (rd && !written[idx]) rd = 1'b0;
      access(rd, a, 16'($urandom), $urandom_range(0, 3), 0, 30, 1'b0, lat);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
